copperv2_bus_arbiter: RTL and testbench
=======================================

# copperv2_bus_arbiter

Single-port memory arbiter for the Copperv2 core. Accepts the core's three independent bus channels (instruction read `ir`, data read `dr`, data write `dw`), grants one at a time by round-robin, and forwards the granted transaction to one unified request/response memory port. One transaction is outstanding at a time. The block sits between the core and a single-ported memory or memory BFM.

## Interface
- `ADDR_WIDTH`, 32, address width of all channels
- `DATA_WIDTH`, 32, data width; multiple of 8
- `STRB_WIDTH`, DATA_WIDTH/8, write byte-strobe width
- `RESP_WIDTH`, 1, write-response width; 0 = OK, nonzero = error

- `clock`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset; asserted when 0
- `bus_ir_addr_valid` / `bus_ir_addr_ready`  in / out  1  ir address handshake
- `bus_ir_addr_bits`  in  ADDR_WIDTH  fetch address
- `bus_ir_data_valid` / `bus_ir_data_ready`  out / in  1  ir data handshake
- `bus_ir_data_bits`  out  DATA_WIDTH  fetched word
- `bus_dr_addr_valid` / `bus_dr_addr_ready` / `bus_dr_addr_bits`: as ir, for data reads
- `bus_dr_data_valid` / `bus_dr_data_ready` / `bus_dr_data_bits`: as ir, for data reads
- `bus_dw_req_valid` / `bus_dw_req_ready`  in / out  1  write request handshake
- `bus_dw_req_bits_addr`  in  ADDR_WIDTH; `bus_dw_req_bits_data`  in  DATA_WIDTH; `bus_dw_req_bits_strobe`  in  STRB_WIDTH
- `bus_dw_resp_valid` / `bus_dw_resp_ready`  out / in  1  write response handshake
- `bus_dw_resp_bits`  out  RESP_WIDTH  write status
- `mem_req_valid` / `mem_req_ready`  out / in  1  memory request handshake
- `mem_req_addr`  out  ADDR_WIDTH; `mem_req_data`  out  DATA_WIDTH; `mem_req_strobe`  out  STRB_WIDTH; `mem_req_write`  out  1
- `mem_resp_valid` / `mem_resp_ready`  in / out  1  memory response handshake
- `mem_resp_data`  in  DATA_WIDTH; `mem_resp_err`  in  RESP_WIDTH

## Operation
- FSM states: IDLE, REQ, RESP, DELIVER. Registers: `state`, `last_grant` (ir/dr/dw), `grant`, the latched request fields, and the latched response data/status.
- IDLE: the combinational grant picks the first valid requester in round-robin order starting after `last_grant` (order ir -> dr -> dw -> ir). Only the granted channel's `*_addr_ready` / `bus_dw_req_ready` is 1. All other readies are 0, and all readies are 0 outside IDLE.
- On the grant handshake: latch addr, data, strobe and write flag (reads use data = 0, strobe = 0); set `grant`; update `last_grant`; go to REQ.
- REQ: `mem_req_valid` = 1 with the latched fields, which are stable until accepted. When `mem_req_ready` = 1, go to RESP.
- RESP: `mem_resp_ready` = 1. When `mem_resp_valid` = 1, latch `mem_resp_data` and `mem_resp_err`, then go to DELIVER.
- DELIVER: assert the granted channel's `*_data_valid` or `bus_dw_resp_valid`, with bits taken from the latched response. Read channels get the data; dw gets `mem_resp_err`. `mem_resp_err` on reads is discarded. Hold until the matching ready is 1, then go to IDLE.
- Response bits outputs are registered and keep their last value outside DELIVER.
- Reset: asynchronous. state = IDLE, `last_grant` = dw (so ir wins the first contention), all latched fields = 0. Every valid and ready output is 0 while `reset` = 0. Reset mid-transaction abandons it; no response is delivered.
- Requester valid is not required to stay high after the grant handshake; the latched copy is authoritative.

## Timing
- Minimum transaction (memory ready and response in the same cycles they are offered): handshake at cycle 0, `mem_req_valid` at cycle 1, `mem_resp_ready` at cycle 2, response valid at cycle 3, next grant possible at cycle 4. Latency is 3 cycles from address handshake to data valid.
- Each cycle of memory or requester back-pressure adds exactly 1 cycle in the corresponding state.
- No combinational path from `mem_*` inputs to core-side outputs. The only combinational paths are core valids -> core readies in IDLE.
- Back-to-back requests from the same channel are allowed. When others are pending, round-robin prevents any channel from waiting more than 2 transactions.

## Test plan
- Single ir fetch of address 0x100, memory returns 0x00000013 with zero wait: `mem_req_addr` = 0x100 and `mem_req_write` = 0 at cycle 1; `bus_ir_data_valid` = 1 with 0x00000013 at cycle 3.
- dw write of addr 0x2000, data 0xDEADBEEF, strobe 0b0011, memory returns err = 1: `mem_req_write` = 1 with the exact fields; `bus_dw_resp_bits` = 1.
- ir, dr and dw all valid continuously from reset: grant order is ir, dr, dw, ir, dr, dw. Exactly one ready is high per IDLE cycle.
- Memory holds `mem_req_ready` = 0 for 5 cycles and `mem_resp_valid` = 0 for 3 cycles: request fields are stable throughout, and data valid arrives at cycle 3 + 8 = 11.
- `bus_dr_data_ready` = 0 for 4 cycles in DELIVER: `bus_dr_data_valid` and the data stay stable, and no new grant occurs until the ready is seen.
- `reset` driven to 0 during RESP: all valids and readies drop immediately without waiting for a clock edge. After release, the first request from the ir channel (addr 0x0) is granted at the first IDLE cycle.

Source files
------------

// File: rtl/copperv2_bus_arbiter.sv
// Round-robin arbiter folding the Copperv2 ir/dr/dw channels onto a single
// request/response memory port, with one transaction in flight at a time.
module copperv2_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int RESP_WIDTH = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bus_ir_addr_valid,
  output logic                  bus_ir_addr_ready,
  input  logic [ADDR_WIDTH-1:0] bus_ir_addr_bits,
  output logic                  bus_ir_data_valid,
  input  logic                  bus_ir_data_ready,
  output logic [DATA_WIDTH-1:0] bus_ir_data_bits,
  input  logic                  bus_dr_addr_valid,
  output logic                  bus_dr_addr_ready,
  input  logic [ADDR_WIDTH-1:0] bus_dr_addr_bits,
  output logic                  bus_dr_data_valid,
  input  logic                  bus_dr_data_ready,
  output logic [DATA_WIDTH-1:0] bus_dr_data_bits,
  input  logic                  bus_dw_req_valid,
  output logic                  bus_dw_req_ready,
  input  logic [ADDR_WIDTH-1:0] bus_dw_req_bits_addr,
  input  logic [DATA_WIDTH-1:0] bus_dw_req_bits_data,
  input  logic [STRB_WIDTH-1:0] bus_dw_req_bits_strobe,
  output logic                  bus_dw_resp_valid,
  input  logic                  bus_dw_resp_ready,
  output logic [RESP_WIDTH-1:0] bus_dw_resp_bits,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_data,
  output logic [STRB_WIDTH-1:0] mem_req_strobe,
  output logic                  mem_req_write,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  input  logic [RESP_WIDTH-1:0] mem_resp_err
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;
  localparam logic [1:0] DELIVER = 2'd3;

  localparam logic [1:0] CH_IR = 2'd0;
  localparam logic [1:0] CH_DR = 2'd1;
  localparam logic [1:0] CH_DW = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            last_grant_q, last_grant_d;
  logic [1:0]            grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strobe_q, strobe_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0] rerr_q, rerr_d;

  logic [2:0] req_vec;
  logic       pick_found;
  logic [1:0] pick;
  logic       idle_ok;
  logic       deliver_ready;

  assign req_vec    = {bus_dw_req_valid, bus_dr_addr_valid, bus_ir_addr_valid};
  assign pick_found = |req_vec;

  // Search starts at the channel after the previous winner.
  always_comb begin
    pick = CH_IR;
    case (last_grant_q)
      CH_IR:   pick = req_vec[1] ? CH_DR : (req_vec[2] ? CH_DW : CH_IR);
      CH_DR:   pick = req_vec[2] ? CH_DW : (req_vec[0] ? CH_IR : CH_DR);
      default: pick = req_vec[0] ? CH_IR : (req_vec[1] ? CH_DR : CH_DW);
    endcase
  end

  // Readies are forced low while reset is held, even though the state is IDLE.
  assign idle_ok           = (state_q == IDLE) && reset;
  assign bus_ir_addr_ready = idle_ok && pick_found && (pick == CH_IR);
  assign bus_dr_addr_ready = idle_ok && pick_found && (pick == CH_DR);
  assign bus_dw_req_ready  = idle_ok && pick_found && (pick == CH_DW);

  assign mem_req_valid     = (state_q == REQ);
  assign mem_resp_ready    = (state_q == RESP);
  assign bus_ir_data_valid = (state_q == DELIVER) && (grant_q == CH_IR);
  assign bus_dr_data_valid = (state_q == DELIVER) && (grant_q == CH_DR);
  assign bus_dw_resp_valid = (state_q == DELIVER) && (grant_q == CH_DW);

  assign mem_req_addr   = addr_q;
  assign mem_req_data   = wdata_q;
  assign mem_req_strobe = strobe_q;
  assign mem_req_write  = write_q;

  assign bus_ir_data_bits = rdata_q;
  assign bus_dr_data_bits = rdata_q;
  assign bus_dw_resp_bits = rerr_q;

  always_comb begin
    case (grant_q)
      CH_IR:   deliver_ready = bus_ir_data_ready;
      CH_DR:   deliver_ready = bus_dr_data_ready;
      default: deliver_ready = bus_dw_resp_ready;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strobe_d     = strobe_q;
    write_d      = write_q;
    rdata_d      = rdata_q;
    rerr_d       = rerr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d      = pick;
          last_grant_d = pick;
          state_d      = REQ;
          case (pick)
            CH_IR: begin
              addr_d   = bus_ir_addr_bits;
              wdata_d  = '0;
              strobe_d = '0;
              write_d  = 1'b0;
            end
            CH_DR: begin
              addr_d   = bus_dr_addr_bits;
              wdata_d  = '0;
              strobe_d = '0;
              write_d  = 1'b0;
            end
            default: begin
              addr_d   = bus_dw_req_bits_addr;
              wdata_d  = bus_dw_req_bits_data;
              strobe_d = bus_dw_req_bits_strobe;
              write_d  = 1'b1;
            end
          endcase
        end
      end
      REQ: begin
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        if (mem_resp_valid) begin
          rdata_d = mem_resp_data;
          rerr_d  = mem_resp_err;
          state_d = DELIVER;
        end
      end
      default: begin
        if (deliver_ready) state_d = IDLE;
      end
    endcase
  end

  // last_grant resets to dw so that ir wins the first contention.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= CH_DW;
      grant_q      <= CH_IR;
      addr_q       <= '0;
      wdata_q      <= '0;
      strobe_q     <= '0;
      write_q      <= 1'b0;
      rdata_q      <= '0;
      rerr_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strobe_q     <= strobe_d;
      write_q      <= write_d;
      rdata_q      <= rdata_d;
      rerr_q       <= rerr_d;
    end
  end
endmodule

// File: tb/tb_copperv2_bus_arbiter.sv
// Randomized bench for copperv2_bus_arbiter: requesters and a memory responder
// are driven from a transaction-level model of the arbitration protocol.
module tb_copperv2_bus_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        bus_ir_addr_valid, bus_ir_addr_ready, bus_ir_data_valid, bus_ir_data_ready;
  logic [31:0] bus_ir_addr_bits, bus_ir_data_bits;
  logic        bus_dr_addr_valid, bus_dr_addr_ready, bus_dr_data_valid, bus_dr_data_ready;
  logic [31:0] bus_dr_addr_bits, bus_dr_data_bits;
  logic        bus_dw_req_valid, bus_dw_req_ready, bus_dw_resp_valid, bus_dw_resp_ready;
  logic [31:0] bus_dw_req_bits_addr, bus_dw_req_bits_data;
  logic [3:0]  bus_dw_req_bits_strobe;
  logic [0:0]  bus_dw_resp_bits;
  logic        mem_req_valid, mem_req_ready, mem_req_write, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_req_addr, mem_req_data, mem_resp_data;
  logic [3:0]  mem_req_strobe;
  logic [0:0]  mem_resp_err;

  always #5 clock = ~clock;

  copperv2_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .bus_ir_addr_valid(bus_ir_addr_valid), .bus_ir_addr_ready(bus_ir_addr_ready),
    .bus_ir_addr_bits(bus_ir_addr_bits), .bus_ir_data_valid(bus_ir_data_valid),
    .bus_ir_data_ready(bus_ir_data_ready), .bus_ir_data_bits(bus_ir_data_bits),
    .bus_dr_addr_valid(bus_dr_addr_valid), .bus_dr_addr_ready(bus_dr_addr_ready),
    .bus_dr_addr_bits(bus_dr_addr_bits), .bus_dr_data_valid(bus_dr_data_valid),
    .bus_dr_data_ready(bus_dr_data_ready), .bus_dr_data_bits(bus_dr_data_bits),
    .bus_dw_req_valid(bus_dw_req_valid), .bus_dw_req_ready(bus_dw_req_ready),
    .bus_dw_req_bits_addr(bus_dw_req_bits_addr), .bus_dw_req_bits_data(bus_dw_req_bits_data),
    .bus_dw_req_bits_strobe(bus_dw_req_bits_strobe), .bus_dw_resp_valid(bus_dw_resp_valid),
    .bus_dw_resp_ready(bus_dw_resp_ready), .bus_dw_resp_bits(bus_dw_resp_bits),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_strobe(mem_req_strobe), .mem_req_write(mem_req_write),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Requesters hold valid until their handshake; index 0 = ir, 1 = dr, 2 = dw.
  logic [2:0]  reqValid;
  logic [31:0] reqAddr [3];
  logic [31:0] dwData;
  logic [3:0]  dwStrb;
  int reqProb, memReqProb, memRespProb, coreProb;
  int reqStall, respStall, coreStall;
  bit fixedResp, releaseNow;
  logic [31:0] fixedData;
  logic        fixedErr;

  // Transaction-level model: the one transaction in flight and the handshake it awaits.
  int          mStage;
  int          mLast, mCh;
  logic [31:0] mAddr, mWdata, mRdata;
  logic [3:0]  mStrb;
  logic        mWrite, mErr;
  int          grantCycle, doneCount;

  // Observations of the DUT for end-of-transaction checks.
  int          obsGrants[$];
  logic [2:0]  lastObsGrant;
  bit          seenReq;
  logic [31:0] obsReqAddr, obsReqData, obsIrBits, obsDrBits;
  logic [3:0]  obsReqStrb;
  logic        obsReqWrite;
  logic [0:0]  obsDwBits;
  int          obsDeliv, obsDelivCycles;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, observed, expected, cycle);
    end
  endtask

  function automatic int rrPick(input int last, input logic [2:0] v);
    for (int k = 1; k <= 3; k++)
      if (v[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  task automatic checkQuiet(input string pfx);
    checkOutput({pfx, "_ir_ready"}, bus_ir_addr_ready, 0);
    checkOutput({pfx, "_dr_ready"}, bus_dr_addr_ready, 0);
    checkOutput({pfx, "_dw_ready"}, bus_dw_req_ready, 0);
    checkOutput({pfx, "_mem_req_valid"}, mem_req_valid, 0);
    checkOutput({pfx, "_mem_resp_ready"}, mem_resp_ready, 0);
    checkOutput({pfx, "_ir_data_valid"}, bus_ir_data_valid, 0);
    checkOutput({pfx, "_dr_data_valid"}, bus_dr_data_valid, 0);
    checkOutput({pfx, "_dw_resp_valid"}, bus_dw_resp_valid, 0);
  endtask

  task automatic modelReset();
    mStage = 0;
    mLast  = 2;
    mCh    = 0;
  endtask

  // One clock: drive at the falling edge, compare 1 time unit later, then advance the model.
  task automatic applyStimulus();
    int p;
    bit rdy;
    @(negedge clock);
    if (releaseNow) begin
      reset = 1'b1;
      releaseNow = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      if (!reqValid[c] && int'($urandom_range(0, 99)) < reqProb) begin
        reqValid[c] = 1'b1;
        reqAddr[c]  = $urandom;
        if (c == 2) begin
          dwData = $urandom;
          dwStrb = 4'($urandom);
        end
      end
    end
    bus_ir_addr_valid      = reqValid[0];
    bus_ir_addr_bits       = reqAddr[0];
    bus_dr_addr_valid      = reqValid[1];
    bus_dr_addr_bits       = reqAddr[1];
    bus_dw_req_valid       = reqValid[2];
    bus_dw_req_bits_addr   = reqAddr[2];
    bus_dw_req_bits_data   = dwData;
    bus_dw_req_bits_strobe = dwStrb;
    if (mStage == 1 && reqStall > 0) begin
      mem_req_ready = 1'b0;
      reqStall--;
    end else mem_req_ready = int'($urandom_range(0, 99)) < memReqProb;
    if (mStage == 2 && respStall > 0) begin
      mem_resp_valid = 1'b0;
      respStall--;
    end else mem_resp_valid = int'($urandom_range(0, 99)) < memRespProb;
    mem_resp_data = fixedResp ? fixedData : $urandom;
    mem_resp_err  = fixedResp ? fixedErr : 1'($urandom);
    if (mStage == 3 && coreStall > 0) begin
      bus_ir_data_ready = 1'b0;
      bus_dr_data_ready = 1'b0;
      bus_dw_resp_ready = 1'b0;
      coreStall--;
    end else begin
      bus_ir_data_ready = int'($urandom_range(0, 99)) < coreProb;
      bus_dr_data_ready = int'($urandom_range(0, 99)) < coreProb;
      bus_dw_resp_ready = int'($urandom_range(0, 99)) < coreProb;
    end
    #1;
    if (!reset) begin
      checkQuiet("in_reset");
      checkOutput("in_reset_req_addr", mem_req_addr, 0);
      checkOutput("in_reset_req_write", mem_req_write, 0);
      checkOutput("in_reset_ir_bits", bus_ir_data_bits, 0);
      checkOutput("in_reset_dw_bits", bus_dw_resp_bits, 0);
      cycle++;
      return;
    end
    p = (mStage == 0) ? rrPick(mLast, reqValid) : -1;
    checkOutput("ir_addr_ready", bus_ir_addr_ready, p == 0);
    checkOutput("dr_addr_ready", bus_dr_addr_ready, p == 1);
    checkOutput("dw_req_ready", bus_dw_req_ready, p == 2);
    checkOutput("mem_req_valid", mem_req_valid, mStage == 1);
    checkOutput("mem_resp_ready", mem_resp_ready, mStage == 2);
    checkOutput("ir_data_valid", bus_ir_data_valid, mStage == 3 && mCh == 0);
    checkOutput("dr_data_valid", bus_dr_data_valid, mStage == 3 && mCh == 1);
    checkOutput("dw_resp_valid", bus_dw_resp_valid, mStage == 3 && mCh == 2);
    if (mStage == 1) begin
      checkOutput("mem_req_addr", mem_req_addr, mAddr);
      checkOutput("mem_req_data", mem_req_data, mWdata);
      checkOutput("mem_req_strobe", mem_req_strobe, mStrb);
      checkOutput("mem_req_write", mem_req_write, mWrite);
    end
    if (mStage == 3) begin
      if (mCh == 2) checkOutput("dw_resp_bits", bus_dw_resp_bits, mErr);
      else if (mCh == 1) checkOutput("dr_data_bits", bus_dr_data_bits, mRdata);
      else checkOutput("ir_data_bits", bus_ir_data_bits, mRdata);
    end
    lastObsGrant = {bus_dw_req_ready & bus_dw_req_valid,
                    bus_dr_addr_ready & bus_dr_addr_valid,
                    bus_ir_addr_ready & bus_ir_addr_valid};
    for (int c = 0; c < 3; c++) if (lastObsGrant[c]) obsGrants.push_back(c);
    if (mem_req_valid && !seenReq) begin
      seenReq     = 1'b1;
      obsReqAddr  = mem_req_addr;
      obsReqData  = mem_req_data;
      obsReqStrb  = mem_req_strobe;
      obsReqWrite = mem_req_write;
    end
    if (bus_ir_data_valid || bus_dr_data_valid || bus_dw_resp_valid) begin
      if (obsDeliv < 0) obsDeliv = cycle;
      obsDelivCycles++;
      obsIrBits = bus_ir_data_bits;
      obsDrBits = bus_dr_data_bits;
      obsDwBits = bus_dw_resp_bits;
    end
    case (mStage)
      0: if (p >= 0) begin
        mCh    = p;
        mLast  = p;
        mAddr  = reqAddr[p];
        mWrite = (p == 2);
        mWdata = (p == 2) ? dwData : 32'h0;
        mStrb  = (p == 2) ? dwStrb : 4'h0;
        reqValid[p] = 1'b0;
        grantCycle = cycle;
        seenReq = 1'b0;
        obsDeliv = -1;
        obsDelivCycles = 0;
        mStage = 1;
      end
      1: if (mem_req_ready) mStage = 2;
      2: if (mem_resp_valid) begin
        mRdata = mem_resp_data;
        mErr   = mem_resp_err;
        mStage = 3;
      end
      default: begin
        rdy = (mCh == 0) ? bus_ir_data_ready : (mCh == 1) ? bus_dr_data_ready : bus_dw_resp_ready;
        if (rdy) begin
          mStage = 0;
          doneCount++;
        end
      end
    endcase
    cycle++;
  endtask

  task automatic runToDone(input string tag, input int budget);
    int start = doneCount;
    int n = 0;
    while (doneCount == start && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput({tag, "_completed"}, doneCount != start, 1);
  endtask

  initial begin
    int n;
    bus_ir_data_ready = 0; bus_dr_data_ready = 0; bus_dw_resp_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0; mem_resp_err = 0;
    bus_ir_addr_valid = 0; bus_dr_addr_valid = 0; bus_dw_req_valid = 0;
    bus_ir_addr_bits = 0; bus_dr_addr_bits = 0; bus_dw_req_bits_addr = 0;
    bus_dw_req_bits_data = 0; bus_dw_req_bits_strobe = 0;
    reqValid = 3'b111;
    for (int c = 0; c < 3; c++) reqAddr[c] = $urandom;
    dwData = $urandom; dwStrb = 4'hF;
    reqProb = 100; memReqProb = 100; memRespProb = 100; coreProb = 100;
    reqStall = 0; respStall = 0; coreStall = 0;
    fixedResp = 0; fixedData = 0; fixedErr = 0; releaseNow = 0;
    doneCount = 0; grantCycle = 0; lastObsGrant = 0; seenReq = 0;
    obsDeliv = -1; obsDelivCycles = 0;
    obsReqAddr = 0; obsReqData = 0; obsReqStrb = 0; obsReqWrite = 0;
    obsIrBits = 0; obsDrBits = 0; obsDwBits = 0;
    mAddr = 0; mWdata = 0; mStrb = 0; mWrite = 0; mRdata = 0; mErr = 0;
    modelReset();

    // Reset with all requesters valid, then continuous contention.
    applyStimulus();
    applyStimulus();
    releaseNow = 1;
    n = 0;
    while (obsGrants.size() < 6 && n < 60) begin
      applyStimulus();
      n++;
    end
    checkOutput("grant_order_count", obsGrants.size() >= 6, 1);
    for (int i = 0; i < 6 && i < obsGrants.size(); i++)
      checkOutput("grant_order", obsGrants[i], i % 3);

    reqProb = 0;
    n = 0;
    while (!(mStage == 0 && reqValid == 3'b000) && n < 80) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_idle", n < 80, 1);

    // Zero-wait ir fetch.
    reqValid[0] = 1; reqAddr[0] = 32'h100;
    fixedResp = 1; fixedData = 32'h0000_0013; fixedErr = 0;
    runToDone("ir_fetch", 20);
    checkOutput("ir_fetch_addr", obsReqAddr, 32'h100);
    checkOutput("ir_fetch_write", obsReqWrite, 0);
    checkOutput("ir_fetch_data", obsIrBits, 32'h0000_0013);
    checkOutput("ir_fetch_latency", obsDeliv - grantCycle, 3);

    // dw write returning an error status.
    reqValid[2] = 1; reqAddr[2] = 32'h2000; dwData = 32'hDEADBEEF; dwStrb = 4'b0011;
    fixedData = 32'h5555_5555; fixedErr = 1;
    runToDone("dw_write", 20);
    checkOutput("dw_write_flag", obsReqWrite, 1);
    checkOutput("dw_write_addr", obsReqAddr, 32'h2000);
    checkOutput("dw_write_data", obsReqData, 32'hDEADBEEF);
    checkOutput("dw_write_strobe", obsReqStrb, 4'b0011);
    checkOutput("dw_write_resp", obsDwBits, 1);

    // dr read under memory and requester back-pressure, with ir waiting behind it.
    reqValid[1] = 1; reqAddr[1] = 32'h300;
    fixedData = 32'hCAFE_0001; fixedErr = 1;
    reqStall = 5; respStall = 3; coreStall = 4;
    n = 0;
    while (mStage != 1 && n < 10) begin
      applyStimulus();
      n++;
    end
    reqValid[0] = 1; reqAddr[0] = 32'h400;
    runToDone("dr_stall", 40);
    checkOutput("dr_stall_latency", obsDeliv - grantCycle, 11);
    checkOutput("dr_stall_deliver_cycles", obsDelivCycles, 5);
    checkOutput("dr_stall_data", obsDrBits, 32'hCAFE_0001);
    applyStimulus();
    checkOutput("dr_stall_next_grant", lastObsGrant, 3'b001);

    // Randomized traffic with back-pressure on every side.
    fixedResp = 0;
    for (int phase = 0; phase < 5; phase++) begin
      reqProb     = $urandom_range(10, 90);
      memReqProb  = $urandom_range(20, 100);
      memRespProb = $urandom_range(20, 100);
      coreProb    = $urandom_range(20, 100);
      repeat (500) applyStimulus();
    end
    checkOutput("random_progress", doneCount > 100, 1);

    // Asynchronous reset in the middle of a response wait.
    reqProb = 100; memReqProb = 100; memRespProb = 100; coreProb = 100;
    respStall = 1000;
    n = 0;
    while (mStage != 2 && n < 100) begin
      applyStimulus();
      n++;
    end
    checkOutput("reach_resp", mStage, 2);
    checkOutput("resp_wait_ready", mem_resp_ready, 1);
    #2;
    reset = 1'b0;
    #1;
    checkQuiet("async_reset");
    modelReset();
    reqStall = 0; respStall = 0; coreStall = 0;
    reqValid = 3'b111; reqAddr[0] = 32'h0;
    applyStimulus();
    releaseNow = 1;
    applyStimulus();
    checkOutput("post_reset_first_grant", lastObsGrant, 3'b001);
    applyStimulus();
    checkOutput("post_reset_req_addr", obsReqAddr, 32'h0);
    repeat (20) applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
